// File: rtl/mac_stop_ctrl.sv
// Sequencer for C = A x B over external single-cycle-read memories.
// One multiply-accumulate per cycle. A stop request aborts the run from any busy state.
module mac_stop_ctrl #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    stop,
    output logic                                    busy,
    output logic                                    done,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]       mem_data_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]       mem_data_b,
    output logic [(M > 1 ? $clog2(M) : 1)-1:0]      row_addr_a,
    output logic [(K > 1 ? $clog2(K) : 1)-1:0]      col_addr_a,
    output logic [(K > 1 ? $clog2(K) : 1)-1:0]      row_addr_b,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]      col_addr_b,
    output logic [(M > 1 ? $clog2(M) : 1)-1:0]      row_addr_c,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]      col_addr_c,
    output logic                                    matrix_a_re,
    output logic                                    matrix_b_re,
    output logic                                    matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]     data_out_c
);

    // state | meaning
    // IDLE  | waiting for start
    // ACCUM | one A*B product per cycle over k for element (i,j)
    // WRITE | accumulator presented to C at (i,j)
    // DONE  | one-cycle completion pulse

    localparam int DW   = DATA_WIDTH_INIT_MATRIX;
    localparam int DWR  = DATA_WIDTH_RESULT_MATRIX;
    localparam int AW_M = (M > 1) ? $clog2(M) : 1;
    localparam int AW_K = (K > 1) ? $clog2(K) : 1;
    localparam int AW_N = (N > 1) ? $clog2(N) : 1;

    // A unit dimension leaves its counter pinned at 0 because LAST is 0.
    localparam logic [AW_M-1:0] M_LAST = AW_M'(M-1);
    localparam logic [AW_K-1:0] K_LAST = AW_K'(K-1);
    localparam logic [AW_N-1:0] N_LAST = AW_N'(N-1);
    localparam logic [AW_M-1:0] M_ONE  = AW_M'(1);
    localparam logic [AW_K-1:0] K_ONE  = AW_K'(1);
    localparam logic [AW_N-1:0] N_ONE  = AW_N'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    state_t           state, state_nxt;
    logic [AW_M-1:0]  i, i_nxt;
    logic [AW_K-1:0]  k, k_nxt;
    logic [AW_N-1:0]  j, j_nxt;
    logic [DWR-1:0]   acc, acc_nxt;
    logic [2*DW-1:0]  prod;
    logic [DWR-1:0]   acc_base;

    assign prod     = {{DW{1'b0}}, mem_data_a} * {{DW{1'b0}}, mem_data_b};
    assign acc_base = (k == '0) ? '0 : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
            acc   <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        i_nxt       = i;
        j_nxt       = j;
        k_nxt       = k;
        acc_nxt     = acc;
        busy        = (state != IDLE);
        done        = 1'b0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        data_out_c  = '0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    i_nxt     = '0;
                    j_nxt     = '0;
                    k_nxt     = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = acc_base + DWR'(prod);
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = WRITE;
                    end else begin
                        k_nxt = k + K_ONE;
                    end
                end
            end
            WRITE: begin
                matrix_c_we = !stop;
                data_out_c  = acc;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (j == N_LAST) begin
                    j_nxt = '0;
                    if (i == M_LAST) begin
                        i_nxt     = '0;
                        state_nxt = DONE;
                    end else begin
                        i_nxt     = i + M_ONE;
                        state_nxt = ACCUM;
                    end
                end else begin
                    j_nxt     = j + N_ONE;
                    state_nxt = ACCUM;
                end
            end
            DONE: begin
                done      = !stop;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign row_addr_a = i;
    assign col_addr_a = k;
    assign row_addr_b = k;
    assign col_addr_b = j;
    assign row_addr_c = i;
    assign col_addr_c = j;

endmodule

// File: doc/mac_stop_ctrl.md
MAC_STOP_CTRL -- requirements
Module: mac_stop_ctrl

Interface
REQ-001 SHALL have parameter M, default 4, rows of A and C.
REQ-002 SHALL have parameter K, default 4, columns of A and rows of B (the inner dimension).
REQ-003 SHALL have parameter N, default 4, columns of B and C.
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX, default 32, width of A/B elements.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX, default 2*DATA_WIDTH_INIT_MATRIX+$clog2(K), width of C elements.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1, request to run C = A x B; sampled only in IDLE.
REQ-009 SHALL have port stop, input, 1, abort request; has priority over all other events.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last C write.
REQ-012 SHALL have port mem_data_a, input, DATA_WIDTH_INIT_MATRIX, combinational read data of A from the memory.
REQ-013 SHALL have port mem_data_b, input, DATA_WIDTH_INIT_MATRIX, combinational read data of B from the memory.
REQ-014 SHALL have port row_addr_a, output, $clog2(M), row i of A.
REQ-015 SHALL have port col_addr_a, output, $clog2(K), column k of A.
REQ-016 SHALL have port row_addr_b, output, $clog2(K), row k of B.
REQ-017 SHALL have port col_addr_b, output, $clog2(N), column j of B.
REQ-018 SHALL have port row_addr_c, output, $clog2(M), row i of C.
REQ-019 SHALL have port col_addr_c, output, $clog2(N), column j of C.
REQ-020 SHALL have port matrix_a_re, output, 1, read enable for A.
REQ-021 SHALL have port matrix_b_re, output, 1, read enable for B.
REQ-022 SHALL have port matrix_c_we, output, 1, write strobe for C.
REQ-023 SHALL have port data_out_c, output, DATA_WIDTH_RESULT_MATRIX, accumulator value written to C.

Function
REQ-024 SHALL implement FSM states IDLE, ACCUM, WRITE and DONE, with registered counters i, j and k.
REQ-025 SHALL, in IDLE with start=1 and stop=0, clear i, j and k to 0 and enter ACCUM; start in any other state SHALL be ignored.
REQ-026 SHALL, in ACCUM, drive matrix_a_re=matrix_b_re=1, A address (i,k) and B address (k,j).
REQ-027 SHALL, in ACCUM, update the accumulator as acc <= (k==0 ? 0 : acc) + mem_data_a*mem_data_b.
  - Arithmetic is unsigned.
  - The product is 2*DATA_WIDTH_INIT_MATRIX bits, zero-extended to DATA_WIDTH_RESULT_MATRIX; no overflow is possible.
REQ-028 SHALL increment k in ACCUM; when k==K-1, k SHALL wrap to 0 and the FSM SHALL enter WRITE.
REQ-029 SHALL, in WRITE, drive matrix_c_we = !stop, C address (i,j) and data_out_c = acc, for exactly one cycle.
REQ-030 SHALL, on leaving WRITE, advance j; on j==N-1, j wraps to 0 and i advances.
  - If i==M-1 and j==N-1: enter DONE.
  - Otherwise: return to ACCUM.
REQ-031 SHALL, in DONE, assert done for one cycle, then return to IDLE.
REQ-032 SHALL keep matrix_a_re, matrix_b_re and matrix_c_we low in IDLE and DONE; addresses there are don't-care but held at counter values.
REQ-033 SHALL make latency from the start-accept edge to done high exactly M*N*(K+1) cycles.
REQ-034 SHALL, when stop=1 in ACCUM, WRITE or DONE, return to IDLE at the next edge.
  - No further C write occurs.
  - done is not pulsed.
  - Already-written C elements are kept.
REQ-035 SHALL, with stop=1 and start=1 together in IDLE, remain in IDLE.
REQ-036 SHALL give identical behaviour when M, N or K equals 1.
  - A 0-width counter is treated as constant 0.
  - ACCUM lasts 1 cycle per element.

Reset
REQ-037 SHALL, while reset=1, force immediately: state=IDLE, i=j=k=0, acc=0, busy=0, done=0, all enables 0, data_out_c=0.
REQ-038 SHALL, if reset is asserted mid-run, perform no C write after assertion; after release, wait in IDLE for start.

Verification
REQ-039 SHALL cover: M=K=N=2, DW=8, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> C writes 19,22,43,50 in order (0,0),(0,1),(1,0),(1,1); done at cycle 12.
REQ-040 SHALL cover: A,B all 8'hFF, K=2 -> every C write equals 2*65025=130050, no truncation.
REQ-041 SHALL cover: stop=1 in the WRITE cycle of element (0,1) -> exactly one C write (0,0), busy low next cycle, no done.
REQ-042 SHALL cover: reset pulsed during ACCUM of element (1,0) -> outputs zero immediately; a new start then gives the full correct result.
REQ-043 SHALL cover: start held high through a run -> ignored while busy; a second run begins on the cycle after DONE.
REQ-044 SHALL cover: M=N=K=1, A=[[7]], B=[[9]] -> single write of 63 on cycle 1, done on cycle 2.
